// File: rtl/peripheral_apb4_master_bridge.sv
// Purpose : valid/ready command port to APB4 master (SETUP/ACCESS), with a PREADY watchdog.
// Latency : command accepted at edge N -> rsp_valid visible after edge N+2, plus one cycle per wait state.
// Backpressure: cmd_ready is high only in IDLE, so one transfer is in flight at a time.
//
// Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   host command handshake
//   cmd_write/addr/wdata/strb  command fields, sampled only on acceptance
//   rsp_valid             one-cycle completion strobe
//   rsp_rdata, rsp_err    read data / error, held until the next rsp_valid
//   PSEL..PWDATA          APB4 master request outputs (all registered)
//   PRDATA, PREADY, PSLVERR  APB4 slave response inputs
module peripheral_apb4_master_bridge #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = PDATA_SIZE / 8;
  // Watchdog counter wide enough to hold TIMEOUT; one bit when the watchdog is disabled.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The transfer is abandoned in the ACCESS cycle whose stalled PREADY would bring
  // the count to TIMEOUT, so TIMEOUT=N allows exactly N ACCESS cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT)     : '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q,     state_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic [PADDR_SIZE-1:0]   paddr_q,     paddr_d;
  logic                    pwrite_q,    pwrite_d;
  logic [STRB_W-1:0]       pstrb_q,     pstrb_d;
  logic [PDATA_SIZE-1:0]   pwdata_q,    pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]        wd_cnt_q,    wd_cnt_d;
  logic                    wd_expire;

  assign wd_expire = (TIMEOUT > 0) && (wd_cnt_q == CNT_LAST);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wd_cnt_d    = wd_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          // Reads never carry byte enables on the bus.
          pstrb_d   = cmd_write ? cmd_strb : '0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wd_cnt_d  = '0;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // A real completion takes priority over a watchdog expiry in the same cycle.
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else if (wd_expire) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          if (wd_cnt_q != CNT_SAT) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
          end
        end else if (wd_cnt_q != CNT_SAT) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State register; reset also aborts any transfer in flight without a response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;
  assign PWDATA    = pwdata_q;

  // APB protocol sanity properties
  a_enable_implies_sel: assert property (@(posedge PCLK) disable iff (PRESET)
    PENABLE |-> PSEL);

  a_setup_then_access: assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && !PENABLE) |=> (PSEL && PENABLE && $stable(PADDR) && $stable(PWRITE)
                            && $stable(PWDATA) && $stable(PSTRB)));

  a_read_no_strobe: assert property (@(posedge PCLK) disable iff (PRESET)
    (PSEL && !PWRITE) |-> (PSTRB == '0));

  a_rsp_single_pulse: assert property (@(posedge PCLK) disable iff (PRESET)
    rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_peripheral_apb4_master_bridge.sv
// Purpose : directed bench for peripheral_apb4_master_bridge (TIMEOUT=4), table vectors plus corner sequences.
// Latency : checks exact SETUP/ACCESS/response cycle placement for every vector.
// Backpressure: slave PREADY is driven per vector; a small GPIO register slave covers end-to-end use.
module tb_peripheral_apb4_master_bridge;

  logic       PCLK;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [0:0] cmd_strb;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL;
  logic       PENABLE;
  logic [3:0] PADDR;
  logic       PWRITE;
  logic [0:0] PSTRB;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  // Directly driven slave response, or the GPIO register slave when use_gpio is set
  logic       use_gpio;
  logic       pready_tb;
  logic       pslverr_tb;
  logic [7:0] prdata_tb;
  logic [7:0] gpio_oe;
  logic [7:0] gpio_o;

  int n_chk;
  int n_fail;

  peripheral_apb4_master_bridge #(
    .PADDR_SIZE(4),
    .PDATA_SIZE(8),
    .TIMEOUT   (4)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_strb (cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PSTRB    (PSTRB),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // GPIO slave: reg 0 = direction (gpio_oe), reg 1 = output (gpio_o), zero wait states
  always @(posedge PCLK) begin
    if (PRESET) begin
      gpio_oe <= 8'h00;
      gpio_o  <= 8'h00;
    end else if (use_gpio && PSEL && PENABLE && PWRITE && PSTRB[0]) begin
      case (PADDR)
        4'h0:    gpio_oe <= PWDATA;
        4'h1:    gpio_o  <= PWDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    PREADY  = pready_tb;
    PSLVERR = pslverr_tb;
    PRDATA  = prdata_tb;
    if (use_gpio) begin
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      PRDATA  = (PADDR == 4'h0) ? gpio_oe : ((PADDR == 4'h1) ? gpio_o : 8'h00);
    end
  end

  typedef struct {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       strb;
    int         waits;      // ACCESS cycles with PREADY low before PREADY high
    logic [7:0] prdata;
    logic       slverr;
    logic       exp_pstrb;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         n_access;   // expected number of ACCESS cycles
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transfer starting at a negedge in IDLE; ends at a negedge in IDLE.
  task automatic run_xfer(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    cmd_valid  = 1'b1;
    cmd_write  = v.write;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cmd_strb   = v.strb;
    pready_tb  = 1'b0;
    pslverr_tb = 1'b0;
    prdata_tb  = ~v.prdata;
    chk({t, " cmd_ready idle"}, cmd_ready, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    // SETUP: scramble the command port, which must now be ignored
    cmd_write = ~v.write;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    cmd_strb  = ~v.strb;
    chk({t, " setup PSEL"},    PSEL, 1);
    chk({t, " setup PENABLE"}, PENABLE, 0);
    chk({t, " setup PADDR"},   PADDR, v.addr);
    chk({t, " setup PWRITE"},  PWRITE, v.write);
    chk({t, " setup PSTRB"},   PSTRB, v.exp_pstrb);
    chk({t, " setup PWDATA"},  PWDATA, v.wdata);
    chk({t, " setup cmd_ready"}, cmd_ready, 0);
    @(posedge PCLK);
    @(negedge PCLK);
    for (int i = 0; i < v.n_access; i++) begin
      chk({t, $sformatf(" access%0d PSEL", i)},    PSEL, 1);
      chk({t, $sformatf(" access%0d PENABLE", i)}, PENABLE, 1);
      chk({t, $sformatf(" access%0d PADDR", i)},   PADDR, v.addr);
      chk({t, $sformatf(" access%0d PWRITE", i)},  PWRITE, v.write);
      chk({t, $sformatf(" access%0d PSTRB", i)},   PSTRB, v.exp_pstrb);
      chk({t, $sformatf(" access%0d PWDATA", i)},  PWDATA, v.wdata);
      chk({t, $sformatf(" access%0d rsp_valid", i)}, rsp_valid, 0);
      chk({t, $sformatf(" access%0d cmd_ready", i)}, cmd_ready, 0);
      pready_tb  = (i == v.waits);
      pslverr_tb = (i == v.waits) && v.slverr;
      prdata_tb  = (i == v.waits) ? v.prdata : ~v.prdata;
      @(posedge PCLK);
      @(negedge PCLK);
    end
    cmd_valid  = 1'b0;
    pready_tb  = 1'b0;
    pslverr_tb = 1'b0;
    prdata_tb  = 8'hE7;
    chk({t, " rsp_valid"}, rsp_valid, 1);
    chk({t, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({t, " rsp_err"},   rsp_err, v.exp_err);
    chk({t, " end PSEL"},  PSEL, 0);
    chk({t, " end PENABLE"}, PENABLE, 0);
    chk({t, " end cmd_ready"}, cmd_ready, 1);
    @(posedge PCLK);
    @(negedge PCLK);
    chk({t, " rsp_valid pulse"}, rsp_valid, 0);
    chk({t, " rsp_rdata hold"},  rsp_rdata, v.exp_rdata);
    chk({t, " rsp_err hold"},    rsp_err, v.exp_err);
    chk({t, " idle PSEL"},       PSEL, 0);
  endtask

  // Transfer against the GPIO slave with a bounded wait for the response.
  task automatic gpio_xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic er);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && !rsp_valid; k++) begin
      @(posedge PCLK);
      @(negedge PCLK);
    end
    chk($sformatf("gpio rsp_valid a%0h", a), rsp_valid, 1);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    vec_t       rv;

    n_chk = 0;
    n_fail = 0;
    use_gpio = 1'b0;
    pready_tb = 1'b0;
    pslverr_tb = 1'b0;
    prdata_tb = 8'h00;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 4'h0;
    cmd_wdata = 8'h00;
    cmd_strb = 1'b0;
    PRESET = 1'b1;

    //          wr    addr   wdata  strb waits prdata slverr pstrb rdata  err  n_access
    vecs[0] = '{1'b1, 4'h1, 8'hA5, 1'b1, 0,  8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1}; // write, zero wait
    vecs[1] = '{1'b0, 4'h2, 8'h77, 1'b1, 2,  8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 3}; // read, 2 waits
    vecs[2] = '{1'b1, 4'h3, 8'h5A, 1'b1, 1,  8'hEE, 1'b1, 1'b1, 8'h00, 1'b1, 2}; // write, PSLVERR
    vecs[3] = '{1'b0, 4'h4, 8'h00, 1'b0, 0,  8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1}; // read, PSLVERR
    vecs[4] = '{1'b0, 4'h5, 8'h11, 1'b1, 15, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 4}; // read timeout
    vecs[5] = '{1'b1, 4'h6, 8'h22, 1'b1, 15, 8'h66, 1'b0, 1'b1, 8'h00, 1'b1, 4}; // write timeout
    vecs[6] = '{1'b0, 4'h7, 8'h33, 1'b1, 3,  8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 4}; // ready on last allowed cycle
    vecs[7] = '{1'b1, 4'hF, 8'h96, 1'b0, 0,  8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1}; // write, strobe 0

    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset PSEL",      PSEL, 0);
    chk("reset PENABLE",   PENABLE, 0);
    chk("reset PADDR",     PADDR, 0);
    chk("reset PWDATA",    PWDATA, 0);
    chk("reset PSTRB",     PSTRB, 0);
    chk("reset PWRITE",    PWRITE, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err",   rsp_err, 0);
    PRESET = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("post-reset cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i], i);
    end

    // Leave non-zero read data on the response so the reset clear is visible.
    run_xfer(vecs[1], 11);

    // Mid-transfer reset during ACCESS, with PREADY high in the same cycle
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h9;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("midrst in ACCESS", PENABLE, 1);
    PRESET    = 1'b1;
    pready_tb = 1'b1;
    prdata_tb = 8'hAB;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("midrst PSEL",      PSEL, 0);
    chk("midrst PENABLE",   PENABLE, 0);
    chk("midrst rsp_valid", rsp_valid, 0);
    chk("midrst rsp_rdata", rsp_rdata, 0);
    PRESET    = 1'b0;
    pready_tb = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("midrst after rsp_valid", rsp_valid, 0);
    chk("midrst after cmd_ready", cmd_ready, 1);
    rv = '{1'b1, 4'hA, 8'h3E, 1'b1, 1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 2};
    run_xfer(rv, 12);

    // End-to-end against the GPIO register slave
    use_gpio = 1'b1;
    gpio_xfer(1'b1, 4'h0, 8'hFF, rd, er);
    chk("gpio dir write err", er, 0);
    gpio_xfer(1'b1, 4'h1, 8'h5A, rd, er);
    chk("gpio out write err", er, 0);
    chk("gpio_oe", gpio_oe, 8'hFF);
    chk("gpio_o",  gpio_o, 8'h5A);
    gpio_xfer(1'b0, 4'h0, 8'h00, rd, er);
    chk("gpio dir readback", rd, 8'hFF);
    gpio_xfer(1'b0, 4'h1, 8'h00, rd, er);
    chk("gpio out readback", rd, 8'h5A);
    chk("gpio read err", er, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
